nic_ring_master: RTL and testbench
==================================

NIC_RING_MASTER -- requirements
Module: nic_ring_master

Interface
REQ-001 Parameter ID, default 6'd1: this node's ring address; used as sid on injected packets and matched against did on arriving packets.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles spent in WAIT before the request is terminated with an error.
REQ-003 Parameter MAX_RETRY, default 3: number of PT_RETRY responses accepted before the request is terminated with an error.
REQ-004 Parameter AGE_MAX, default 6'd63: age at which a circulating packet is dropped.
REQ-005 rst_i  in  1  reset; asynchronous, active-high.
REQ-006 clk_i  in  1  single clock for all logic.
REQ-007 packet_i  in  Packet  ring input, one packet per cycle; typ PT_NULL means an empty slot.
REQ-008 packet_o  out  Packet  registered ring output.
REQ-009 cyc_i, we_i  in  1 each  local bus cycle request and write select.
REQ-010 adr_i  in  Address  local bus address; dat_i  in  Data  local bus write data.
REQ-011 did_i  in  6  destination node for the local request.
REQ-012 ack_o, err_o  out  1 each  local bus completion and error.
REQ-013 dat_o  out  Data  read data returned on a PT_ACK response.
REQ-014 rx_o  out  Packet  non-response packets addressed to this node.
REQ-015 rx_valid_o  out  1  rx_o is valid; rx_ready_i  in  1  consumer accepts rx_o.

Function
REQ-016 packet_o SHALL update every clk_i edge, giving 1-cycle ring latency from packet_i.
REQ-017 Arriving packets are classified with this priority:
  - Response: did==ID, typ PT_ACK or PT_RETRY, sid==latched destination, FSM in WAIT. Consumed; the output slot becomes free.
  - Stale: did==ID, typ PT_ACK or PT_RETRY, not matching a Response. Discarded; the output slot becomes free.
  - Deliver: did==ID, other non-NULL typ, rx_valid_o low or being accepted this cycle. Loaded into rx_o, rx_valid_o set; the output slot becomes free.
  - Drop: any other non-NULL packet with age==AGE_MAX. Output PT_NULL, all other fields zero.
  - Forward: any other non-NULL packet, including did==ID with rx busy. Output with age+1; all other fields unchanged.
  - A PT_NULL input yields a free slot.
REQ-018 rx_valid_o SHALL clear on the cycle after rx_valid_o && rx_ready_i unless a new Deliver occurs on the same edge; rx_o SHALL hold stable while rx_valid_o && !rx_ready_i.
REQ-019 FSM states: IDLE, INJECT, WAIT, RESP.
REQ-020 IDLE: when cyc_i is high, latch we_i, adr_i, dat_i and did_i, clear the retry count, and go to INJECT.
REQ-021 INJECT: when the output slot is free this cycle, emit the latched request packet and go to WAIT; otherwise remain in INJECT. Ring traffic always has priority over injection.
REQ-022 Injected packet fields: did = latched destination, sid=ID, age=0, ack=0, pad2=0, we = latched we, adr/dat = latched values. typ = PT_WRITE when we, else PT_READ.
REQ-023 WAIT: a timeout counter clears on entry and increments every cycle.
  - Response PT_ACK: load dat_o from packet_i.dat and go to RESP with ack_o.
  - Response PT_RETRY with retry count < MAX_RETRY: increment the retry count and go to INJECT.
  - Response PT_RETRY with retry count == MAX_RETRY: go to RESP with err_o.
  - Counter reaching TIMEOUT with no Response that cycle: go to RESP with err_o.
  - A Response on the same cycle the counter reaches TIMEOUT SHALL win over the timeout.
REQ-024 RESP: ack_o or err_o (never both) SHALL be held high until cyc_i is sampled low; the FSM then returns to IDLE and deasserts both on that edge.
REQ-025 cyc_i dropping in INJECT or WAIT SHALL abandon the request and return to IDLE; any later response is then Stale.
REQ-026 Age arithmetic is 6-bit; the Drop rule guarantees no wrap-around.

Reset
REQ-027 While rst_i is high, asynchronously:
  - packet_o = all zero (PT_NULL), rx_o = 0, rx_valid_o = 0;
  - ack_o = 0, err_o = 0, dat_o = 0;
  - FSM = IDLE; retry and timeout counters = 0.
REQ-028 Reset mid-transaction SHALL discard the pending request with no completion signalled.

Structure
REQ-029 Packet, Address, Data, the PT_* codes and a new FSM state enum SHALL live in nic_pkg; AGE_MAX stays a module parameter.
REQ-030 Sub-module nic_rx_slot (1-entry valid/ready holding register) SHALL implement rx_o, rx_valid_o and rx_ready_i.

Verification
REQ-031 ID=1, idle bus; packet_i {did=5, age=7, typ=PT_WRITE} -> next cycle packet_o is the same packet with age=8.
REQ-032 packet_i {did=5, age=63} -> next cycle packet_o is all zero.
REQ-033 cyc=1, we=0, adr=24'h001234, did_i=3; ring busy for 4 cycles, then PT_NULL -> PT_READ injected on the free slot; after PT_ACK {did=1, sid=3, dat=12'hABC}, ack_o=1 and dat_o=12'hABC, held until cyc_i drops.
REQ-034 Write request answered by 4 consecutive PT_RETRY responses -> exactly 4 injections, then err_o=1.
REQ-035 Read with no response -> err_o asserted TIMEOUT+1 cycles after entering WAIT; a PT_ACK arriving afterwards is discarded, slot output is PT_NULL.
REQ-036 Two consecutive PT_WRITE packets to did=1 with rx_ready_i=0 -> first held in rx_o, second forwarded with age+1; rx_o unchanged until rx_ready_i=1.

Source files
------------

// File: rtl/nic_pkg.sv
// Shared ring packet format, local bus types and master FSM states for the NIC ring.
package nic_pkg;

    localparam int unsigned NODE_W = 6;
    localparam int unsigned AGE_W  = 6;
    localparam int unsigned ADR_W  = 24;
    localparam int unsigned DAT_W  = 12;

    typedef logic [ADR_W-1:0] Address;
    typedef logic [DAT_W-1:0] Data;

    typedef enum logic [2:0] {
        PT_NULL  = 3'd0,
        PT_READ  = 3'd1,
        PT_WRITE = 3'd2,
        PT_ACK   = 3'd3,
        PT_RETRY = 3'd4
    } pt_e;

    typedef struct packed {
        logic [NODE_W-1:0] did;
        logic [NODE_W-1:0] sid;
        logic [AGE_W-1:0]  age;
        pt_e               typ;
        logic              ack;
        logic [1:0]        pad2;
        logic              we;
        Address            adr;
        Data               dat;
    } Packet;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INJECT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    function automatic logic is_resp_typ(input pt_e t);
        return (t == PT_ACK) || (t == PT_RETRY);
    endfunction

endpackage

// File: rtl/nic_rx_slot.sv
// One-entry valid/ready holding register for packets delivered to this node.
module nic_rx_slot
    import nic_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  load,
    input  Packet pkt,
    input  logic  ready,
    output Packet rx,
    output logic  rx_valid,
    output logic  accept_c
);

    assign accept_c = !rx_valid || ready;

    // A load on the same edge as a handshake replaces the accepted entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx       <= '0;
            rx_valid <= 1'b0;
        end else if (load) begin
            rx       <= pkt;
            rx_valid <= 1'b1;
        end else if (rx_valid && ready) begin
            rx_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/nic_ring_master.sv
// Ring node: forwards/ages/drops ring traffic, delivers local packets, and runs
// one local bus request at a time as an injected packet awaiting ACK/RETRY.
module nic_ring_master
    import nic_pkg::*;
#(
    parameter logic [5:0]  ID        = 6'd1,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned MAX_RETRY = 3,
    parameter logic [5:0]  AGE_MAX   = 6'd63
) (
    input  logic       rst_i,
    input  logic       clk_i,
    input  Packet      packet_i,
    output Packet      packet_o,
    input  logic       cyc_i,
    input  logic       we_i,
    input  Address     adr_i,
    input  Data        dat_i,
    input  logic [5:0] did_i,
    output logic       ack_o,
    output logic       err_o,
    output Data        dat_o,
    output Packet      rx_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i
);

    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1) + 1;
    localparam int unsigned RCNT_W = $clog2(MAX_RETRY + 1) + 1;

    state_e            state_q, state_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              req_we_q, req_we_d;
    Address            req_adr_q, req_adr_d;
    Data               req_dat_q, req_dat_d;
    logic [5:0]        req_did_q, req_did_d;
    logic              ack_d, err_d;
    Data               dat_d;
    Packet             packet_d;

    logic  to_me_c, resp_typ_c, nonnull_c, response_c, deliver_c, forward_c;
    logic  rx_accept_c, inject_c;
    Packet inj_pkt_c;

    // Arrival classification; anything not forwarded leaves a free output slot.
    always_comb begin
        to_me_c    = (packet_i.did == ID);
        resp_typ_c = is_resp_typ(packet_i.typ);
        nonnull_c  = (packet_i.typ != PT_NULL);
        response_c = to_me_c && resp_typ_c && (packet_i.sid == req_did_q) && (state_q == ST_WAIT);
        deliver_c  = to_me_c && nonnull_c && !resp_typ_c && rx_accept_c;
        forward_c  = nonnull_c && !(to_me_c && resp_typ_c) && !deliver_c && (packet_i.age != AGE_MAX);
    end

    always_comb begin
        inj_pkt_c     = '0;
        inj_pkt_c.did = req_did_q;
        inj_pkt_c.sid = ID;
        inj_pkt_c.we  = req_we_q;
        inj_pkt_c.adr = req_adr_q;
        inj_pkt_c.dat = req_dat_q;
        inj_pkt_c.typ = req_we_q ? PT_WRITE : PT_READ;
    end

    nic_rx_slot u_rx_slot (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (deliver_c),
        .pkt      (packet_i),
        .ready    (rx_ready_i),
        .rx       (rx_o),
        .rx_valid (rx_valid_o),
        .accept_c (rx_accept_c)
    );

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        rcnt_d    = rcnt_q;
        req_we_d  = req_we_q;
        req_adr_d = req_adr_q;
        req_dat_d = req_dat_q;
        req_did_d = req_did_q;
        ack_d     = ack_o;
        err_d     = err_o;
        dat_d     = dat_o;
        inject_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cyc_i) begin
                    req_we_d  = we_i;
                    req_adr_d = adr_i;
                    req_dat_d = dat_i;
                    req_did_d = did_i;
                    rcnt_d    = '0;
                    state_d   = ST_INJECT;
                end
            end
            ST_INJECT: begin
                if (!cyc_i) begin
                    state_d = ST_IDLE;
                end else if (!forward_c) begin
                    inject_c = 1'b1;
                    tcnt_d   = '0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response on the timeout cycle takes precedence.
                if (!cyc_i) begin
                    state_d = ST_IDLE;
                end else if (response_c && (packet_i.typ == PT_ACK)) begin
                    dat_d   = packet_i.dat;
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (response_c && (rcnt_q < RCNT_W'(MAX_RETRY))) begin
                    rcnt_d  = rcnt_q + RCNT_W'(1);
                    state_d = ST_INJECT;
                end else if (response_c || (tcnt_q == TCNT_W'(TIMEOUT))) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            ST_RESP: begin
                if (!cyc_i) begin
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        packet_d = '0;
        if (forward_c) begin
            packet_d     = packet_i;
            packet_d.age = packet_i.age + AGE_W'(1);
        end else if (inject_c) begin
            packet_d = inj_pkt_c;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            tcnt_q    <= '0;
            rcnt_q    <= '0;
            req_we_q  <= 1'b0;
            req_adr_q <= '0;
            req_dat_q <= '0;
            req_did_q <= '0;
            ack_o     <= 1'b0;
            err_o     <= 1'b0;
            dat_o     <= '0;
            packet_o  <= '0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            rcnt_q    <= rcnt_d;
            req_we_q  <= req_we_d;
            req_adr_q <= req_adr_d;
            req_dat_q <= req_dat_d;
            req_did_q <= req_did_d;
            ack_o     <= ack_d;
            err_o     <= err_d;
            dat_o     <= dat_d;
            packet_o  <= packet_d;
        end
    end

endmodule

// File: tb/tb_nic_ring_master.sv
// Self-checking bench for nic_ring_master: vector table, randomized ring traffic
// against a rule-level model, and hand sequences for the request FSM.
module tb_nic_ring_master;
    import nic_pkg::*;

    localparam logic [5:0] ID = 6'd1;
    localparam int TO = 255;
    localparam int MR = 3;

    logic       clk = 1'b0;
    logic       rst;
    Packet      packet_i, packet_o, rx_o;
    logic       cyc, we, ack, err, rxv, rdy;
    Address     adr;
    Data        dat_i, dat_o;
    logic [5:0] did;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nic_ring_master #(.ID(ID), .TIMEOUT(TO), .MAX_RETRY(MR), .AGE_MAX(6'd63)) dut (
        .rst_i(rst), .clk_i(clk), .packet_i(packet_i), .packet_o(packet_o),
        .cyc_i(cyc), .we_i(we), .adr_i(adr), .dat_i(dat_i), .did_i(did),
        .ack_o(ack), .err_o(err), .dat_o(dat_o),
        .rx_o(rx_o), .rx_valid_o(rxv), .rx_ready_i(rdy)
    );

    typedef struct {
        Packet pin;
        logic  rdy;
        Packet pout;
        logic  rxv;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic Packet mk(input logic [5:0] d, input logic [5:0] s, input logic [5:0] a,
                                 input pt_e t, input logic w, input Address ad, input Data dt);
        Packet p;
        p     = '0;
        p.did = d;
        p.sid = s;
        p.age = a;
        p.typ = t;
        p.we  = w;
        p.adr = ad;
        p.dat = dt;
        return p;
    endfunction

    Packet busy, exp_p, w1, w2, ip;
    logic  m_full;
    Packet m_pkt;
    int    inj, k_err;
    logic  seen;

    initial begin
        rst = 1'b1;
        packet_i = '0; cyc = 0; we = 0; adr = '0; dat_i = '0; did = '0; rdy = 1'b1;
        step();
        step();
        chk("rst_packet_o", 64'(packet_o), 64'd0);
        chk("rst_rx_valid", 64'(rxv), 64'd0);
        chk("rst_ack_err", 64'({ack, err}), 64'd0);
        chk("rst_dat_o", 64'(dat_o), 64'd0);
        rst = 1'b0;

        // classification vectors with an idle local bus
        vt.push_back('{mk(5,2,7,PT_WRITE,1,24'h0000AA,12'h055), 1'b1, mk(5,2,8,PT_WRITE,1,24'h0000AA,12'h055), 1'b0});
        vt.push_back('{mk(5,2,63,PT_READ,0,24'h000001,12'h001), 1'b1, Packet'('0), 1'b0});
        vt.push_back('{Packet'('0), 1'b1, Packet'('0), 1'b0});
        vt.push_back('{mk(1,3,0,PT_ACK,0,24'h0,12'hABC), 1'b1, Packet'('0), 1'b0});
        vt.push_back('{mk(1,4,9,PT_RETRY,0,24'h0,12'h0), 1'b1, Packet'('0), 1'b0});
        vt.push_back('{mk(1,6,2,PT_WRITE,1,24'h000033,12'h033), 1'b1, Packet'('0), 1'b1});
        vt.push_back('{mk(9,1,62,PT_READ,0,24'h000044,12'h044), 1'b1, mk(9,1,63,PT_READ,0,24'h000044,12'h044), 1'b0});
        vt.push_back('{mk(1,7,63,PT_WRITE,1,24'h000055,12'h055), 1'b1, Packet'('0), 1'b1});
        vt.push_back('{Packet'('0), 1'b1, Packet'('0), 1'b0});
        vt.push_back('{mk(2,1,0,PT_READ,0,24'h000066,12'h066), 1'b1, mk(2,1,1,PT_READ,0,24'h000066,12'h066), 1'b0});
        foreach (vt[i]) begin
            packet_i = vt[i].pin;
            rdy      = vt[i].rdy;
            step();
            chk($sformatf("vec%0d_packet_o", i), 64'(packet_o), 64'(vt[i].pout));
            chk($sformatf("vec%0d_rx_valid", i), 64'(rxv), 64'(vt[i].rxv));
        end

        // random ring traffic, no local request: every response to ID is stale
        m_full = 1'b0;
        m_pkt  = '0;
        for (int n = 0; n < 300; n++) begin
            ip     = '0;
            ip.did = ($urandom_range(0, 3) == 0) ? ID : 6'($urandom_range(0, 63));
            ip.sid = 6'($urandom_range(0, 63));
            ip.age = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 63));
            ip.typ = pt_e'(3'($urandom_range(0, 4)));
            ip.ack = 1'($urandom_range(0, 1));
            ip.we  = 1'($urandom_range(0, 1));
            ip.adr = 24'($urandom);
            ip.dat = 12'($urandom);
            packet_i = ip;
            rdy      = 1'($urandom_range(0, 1));
            exp_p    = '0;
            if (ip.typ == PT_NULL) begin
                exp_p = '0;
            end else if (ip.did == ID && (ip.typ == PT_ACK || ip.typ == PT_RETRY)) begin
                exp_p = '0;
            end else if (ip.did == ID && (!m_full || rdy)) begin
                exp_p  = '0;
                m_full = 1'b1;
                m_pkt  = ip;
            end else if (ip.age == 6'd63) begin
                exp_p = '0;
            end else begin
                exp_p     = ip;
                exp_p.age = ip.age + 6'd1;
            end
            if (!(ip.did == ID && ip.typ != PT_NULL && ip.typ != PT_ACK && ip.typ != PT_RETRY && (!m_full || rdy)) && m_full && rdy)
                m_full = 1'b0;
            step();
            chk("rnd_packet_o", 64'(packet_o), 64'(exp_p));
            chk("rnd_rx_valid", 64'(rxv), 64'(m_full));
            if (m_full) chk("rnd_rx_o", 64'(rx_o), 64'(m_pkt));
        end
        packet_i = '0; rdy = 1'b1;
        step();

        // read: ring busy 4 cycles, inject on first free slot, ACK returns data
        busy = mk(5,9,0,PT_WRITE,1,24'h000001,12'h001);
        cyc = 1; we = 0; adr = 24'h001234; dat_i = '0; did = 6'd3; packet_i = busy;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("busy_fwd", 64'(packet_o), 64'(mk(5,9,1,PT_WRITE,1,24'h000001,12'h001)));
        end
        packet_i = '0;
        step();
        chk("read_inject", 64'(packet_o), 64'(mk(3,1,0,PT_READ,0,24'h001234,12'h000)));
        step();
        packet_i = mk(1,3,0,PT_ACK,0,24'h0,12'hABC);
        step();
        chk("read_ack", 64'({ack, err}), 64'b10);
        chk("read_dat_o", 64'(dat_o), 64'h0ABC);
        chk("resp_consumed", 64'(packet_o), 64'd0);
        packet_i = '0;
        step();
        step();
        chk("ack_held", 64'({ack, err}), 64'b10);
        cyc = 0;
        step();
        chk("ack_release", 64'({ack, err}), 64'b00);

        // write answered by retries until the retry budget is exhausted
        cyc = 1; we = 1; adr = 24'h00BEEF; dat_i = 12'h5A5; did = 6'd4; packet_i = '0;
        exp_p = mk(4,1,0,PT_WRITE,1,24'h00BEEF,12'h5A5);
        inj = 0;
        for (int r = 0; r <= MR; r++) begin
            seen = 1'b0;
            for (int w = 0; w < 10 && !seen; w++) begin
                step();
                if (packet_o == exp_p) begin
                    inj++;
                    seen = 1'b1;
                end
            end
            packet_i = mk(1,4,0,PT_RETRY,0,24'h0,12'h0);
            step();
            packet_i = '0;
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (packet_o == exp_p) inj++;
        end
        chk("retry_injections", 64'(inj), 64'(MR + 1));
        chk("retry_err", 64'({ack, err}), 64'b01);
        cyc = 0;
        step();
        chk("retry_err_release", 64'({ack, err}), 64'b00);

        // read with no answer times out; a late ACK is stale
        cyc = 1; we = 0; adr = 24'h000777; dat_i = '0; did = 6'd2; packet_i = '0;
        step();
        step();
        chk("to_inject", 64'(packet_o), 64'(mk(2,1,0,PT_READ,0,24'h000777,12'h000)));
        k_err = -1;
        for (int k = 1; k <= TO + 5 && k_err < 0; k++) begin
            step();
            if (err) k_err = k;
        end
        chk("timeout_latency", 64'(k_err), 64'(TO + 1));
        packet_i = mk(1,2,0,PT_ACK,0,24'h0,12'hFFF);
        step();
        chk("late_ack_slot", 64'(packet_o), 64'd0);
        chk("late_ack_flags", 64'({ack, err}), 64'b01);
        chk("late_ack_dat", 64'(dat_o), 64'h0ABC);
        packet_i = '0; cyc = 0;
        step();

        // response arriving exactly on the timeout cycle wins
        cyc = 1; did = 6'd2;
        step();
        step();
        for (int k = 1; k <= TO; k++) step();
        chk("pre_timeout_flags", 64'({ack, err}), 64'b00);
        packet_i = mk(1,2,0,PT_ACK,0,24'h0,12'h321);
        step();
        chk("ack_beats_timeout", 64'({ack, err}), 64'b10);
        chk("ack_beats_dat", 64'(dat_o), 64'h0321);
        packet_i = '0; cyc = 0;
        step();

        // rx slot back-pressure: second packet to ID is forwarded
        rdy = 0;
        w1 = mk(1,7,0,PT_WRITE,1,24'h000010,12'h111);
        w2 = mk(1,8,4,PT_WRITE,1,24'h000020,12'h222);
        packet_i = w1;
        step();
        chk("rx_load_valid", 64'(rxv), 64'd1);
        chk("rx_load_pkt", 64'(rx_o), 64'(w1));
        packet_i = w2;
        step();
        chk("rx_busy_fwd", 64'(packet_o), 64'(mk(1,8,5,PT_WRITE,1,24'h000020,12'h222)));
        packet_i = '0;
        step();
        step();
        chk("rx_hold", 64'(rx_o), 64'(w1));
        chk("rx_hold_valid", 64'(rxv), 64'd1);
        rdy = 1;
        step();
        chk("rx_drain", 64'(rxv), 64'd0);

        // abandoned request: the later ACK is stale
        cyc = 1; we = 0; did = 6'd5;
        step();
        step();
        cyc = 0;
        step();
        packet_i = mk(1,5,0,PT_ACK,0,24'h0,12'h0EE);
        step();
        chk("abandon_slot", 64'(packet_o), 64'd0);
        chk("abandon_flags", 64'({ack, err}), 64'b00);
        packet_i = '0;

        // deliver frees the slot for injection; reset mid-request discards it
        rdy = 0; cyc = 1; we = 1; adr = 24'h000abc; dat_i = 12'h0DD; did = 6'd6;
        step();
        packet_i = mk(1,9,3,PT_READ,0,24'h000099,12'h099);
        step();
        chk("deliver_inject", 64'(packet_o), 64'(mk(6,1,0,PT_WRITE,1,24'h000abc,12'h0DD)));
        chk("deliver_valid", 64'(rxv), 64'd1);
        packet_i = '0;
        rst = 1'b1;
        #1;
        chk("async_rst_packet", 64'(packet_o), 64'd0);
        chk("async_rst_rx", 64'(rxv), 64'd0);
        chk("async_rst_dat", 64'(dat_o), 64'd0);
        cyc = 0;
        step();
        rst = 1'b0;
        step();
        packet_i = mk(1,6,0,PT_ACK,0,24'h0,12'h0AA);
        step();
        chk("post_rst_ack_stale", 64'({ack, err}), 64'b00);
        chk("post_rst_slot", 64'(packet_o), 64'd0);
        packet_i = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
